// File: rtl/cva6_cfg_shadow_bank_if.sv
// Host/debug write port of the per-hart configuration bank.
interface cva6_cfg_shadow_bank_if #(
    parameter int unsigned NrHarts    = 2,
    parameter int unsigned NrFields   = 8,
    parameter int unsigned FieldWidth = 32
);
    localparam int unsigned HW = (NrHarts > 1) ? $clog2(NrHarts) : 1;
    localparam int unsigned FW = (NrFields > 1) ? $clog2(NrFields) : 1;

    logic                  wr_req_i;
    logic                  wr_bcast_i;
    logic [HW-1:0]         wr_hart_i;
    logic [FW-1:0]         wr_field_i;
    logic [FieldWidth-1:0] wr_data_i;
    logic                  wr_gnt_o;
    logic                  wr_err_o;

    modport master (
        output wr_req_i, wr_bcast_i, wr_hart_i, wr_field_i, wr_data_i,
        input  wr_gnt_o, wr_err_o
    );

    modport slave (
        input  wr_req_i, wr_bcast_i, wr_hart_i, wr_field_i, wr_data_i,
        output wr_gnt_o, wr_err_o
    );
endinterface

// File: rtl/cva6_cfg_shadow_bank.sv
// Per-hart configuration bank: host writes land in a shadow copy, which is
// committed to the active copy on an apply request once the hart is idle.
//
// write FSM  | meaning
// W_IDLE     | accepting a write; checked and performed at the sampling edge
// W_RESP     | wr_gnt_o/wr_err_o presented for one cycle
// commit FSM | meaning (one per hart)
// C_IDLE     | no commit requested
// C_WAIT     | commit requested, waiting for hart_idle_i
// C_COMMIT   | active <= shadow this cycle, apply_done_o asserted
module cva6_cfg_shadow_bank #(
    parameter int unsigned                      NrHarts    = 2,
    parameter int unsigned                      NrFields   = 8,
    parameter int unsigned                      FieldWidth = 32,
    parameter logic [NrFields*FieldWidth-1:0]   RstVal     = '0,
    parameter logic [NrFields-1:0]              LockMask   = '1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    cva6_cfg_shadow_bank_if.slave                  wr,
    input  logic [NrHarts-1:0]                     lock_i,
    input  logic [NrHarts-1:0]                     apply_req_i,
    input  logic [NrHarts-1:0]                     hart_idle_i,
    output logic [NrHarts-1:0]                     apply_done_o,
    output logic [NrHarts-1:0]                     pending_o,
    output logic [NrHarts-1:0]                     locked_o,
    output logic [NrHarts*NrFields*FieldWidth-1:0] cfg_o
);
    localparam int unsigned HW = (NrHarts > 1) ? $clog2(NrHarts) : 1;

    typedef logic [FieldWidth-1:0] field_t;
    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_COMMIT} commit_state_e;

    field_t        shadow_q [NrHarts][NrFields];
    field_t        shadow_d [NrHarts][NrFields];
    field_t        active_q [NrHarts][NrFields];
    field_t        active_d [NrHarts][NrFields];
    commit_state_e cstate_q [NrHarts];
    commit_state_e cstate_d [NrHarts];
    wr_state_e     wstate_q, wstate_d;
    logic [NrHarts-1:0] dirty_q, dirty_d;
    logic [NrHarts-1:0] locked_q, locked_d;
    logic [NrHarts-1:0] done_q, done_d;
    logic               gnt_q, gnt_d;
    logic               err_q, err_d;

    logic               wr_fire;
    logic               field_ok;
    logic               hart_ok;
    logic               mask_bit;
    logic               tgt_blocked;
    logic               wr_bad;
    logic [NrHarts-1:0] we;

    // Lock checks use locked_q, so a lock pulse in the same cycle has no effect yet.
    always_comb begin
        wr_fire     = (wstate_q == W_IDLE) && wr.wr_req_i;
        field_ok    = 32'(wr.wr_field_i) < NrFields;
        hart_ok     = 32'(wr.wr_hart_i) < NrHarts;
        mask_bit    = field_ok ? LockMask[wr.wr_field_i] : 1'b0;
        tgt_blocked = 1'b0;
        for (int h = 0; h < NrHarts; h++) begin
            if (wr.wr_hart_i == HW'(h)) tgt_blocked = locked_q[h] && mask_bit;
        end
        wr_bad = !field_ok || (!wr.wr_bcast_i && (!hart_ok || tgt_blocked));
        we     = '0;
        for (int h = 0; h < NrHarts; h++) begin
            we[h] = wr_fire && !wr_bad &&
                    (wr.wr_bcast_i ? !(locked_q[h] && mask_bit)
                                   : (wr.wr_hart_i == HW'(h)));
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cstate_d = cstate_q;
        dirty_d  = dirty_q;
        locked_d = locked_q | lock_i;
        done_d   = '0;
        gnt_d    = wr_fire;
        err_d    = wr_fire && wr_bad;
        wstate_d = wr_fire ? W_RESP : W_IDLE;
        for (int h = 0; h < NrHarts; h++) begin
            case (cstate_q[h])
                C_IDLE: begin
                    if (apply_req_i[h]) cstate_d[h] = C_WAIT;
                end
                C_WAIT: begin
                    if (hart_idle_i[h]) begin
                        cstate_d[h] = C_COMMIT;
                        done_d[h]   = 1'b1;
                    end
                end
                C_COMMIT: begin
                    active_d[h] = shadow_q[h];
                    dirty_d[h]  = 1'b0;
                    cstate_d[h] = C_IDLE;
                end
                default: cstate_d[h] = C_IDLE;
            endcase
            // A write coinciding with commit: active gets the old shadow, dirty stays set.
            if (we[h]) begin
                shadow_d[h][wr.wr_field_i] = wr.wr_data_i;
                dirty_d[h]                 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int h = 0; h < NrHarts; h++) begin
                for (int f = 0; f < NrFields; f++) begin
                    shadow_q[h][f] <= RstVal[f*FieldWidth +: FieldWidth];
                    active_q[h][f] <= RstVal[f*FieldWidth +: FieldWidth];
                end
                cstate_q[h] <= C_IDLE;
            end
            wstate_q <= W_IDLE;
            dirty_q  <= '0;
            locked_q <= '0;
            done_q   <= '0;
            gnt_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cstate_q <= cstate_d;
            wstate_q <= wstate_d;
            dirty_q  <= dirty_d;
            locked_q <= locked_d;
            done_q   <= done_d;
            gnt_q    <= gnt_d;
            err_q    <= err_d;
        end
    end

    assign wr.wr_gnt_o  = gnt_q;
    assign wr.wr_err_o  = err_q;
    assign apply_done_o = done_q;
    assign pending_o    = dirty_q;
    assign locked_o     = locked_q;

    for (genvar h = 0; h < NrHarts; h++) begin : g_hart
        for (genvar f = 0; f < NrFields; f++) begin : g_field
            assign cfg_o[(h*NrFields+f)*FieldWidth +: FieldWidth] = active_q[h][f];
        end
    end
endmodule

// File: tb/tb_cva6_cfg_shadow_bank.sv
// Directed bench for cva6_cfg_shadow_bank with 3 harts x 6 fields so that
// out-of-range hart and field indices are encodable.
module tb_cva6_cfg_shadow_bank;
    localparam int unsigned NH = 3;
    localparam int unsigned NF = 6;
    localparam int unsigned DW = 32;
    localparam logic [NF*DW-1:0] RST = {32'h1000_0005, 32'h1000_0004, 32'h1000_0003,
                                        32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    localparam logic [NF-1:0] LMASK = 6'b01_1111;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [NH-1:0]    lock_i, apply_req_i, hart_idle_i;
    logic [NH-1:0]    apply_done_o, pending_o, locked_o;
    logic [NH*NF*DW-1:0] cfg_o;

    int n_chk  = 0;
    int n_pass = 0;

    cva6_cfg_shadow_bank_if #(.NrHarts(NH), .NrFields(NF), .FieldWidth(DW)) wr_if ();

    cva6_cfg_shadow_bank #(
        .NrHarts(NH), .NrFields(NF), .FieldWidth(DW), .RstVal(RST), .LockMask(LMASK)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .wr           (wr_if),
        .lock_i       (lock_i),
        .apply_req_i  (apply_req_i),
        .hart_idle_i  (hart_idle_i),
        .apply_done_o (apply_done_o),
        .pending_o    (pending_o),
        .locked_o     (locked_o),
        .cfg_o        (cfg_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [DW-1:0] cfg_f(input int h, input int f);
        return cfg_o[(h*NF+f)*DW +: DW];
    endfunction

    task automatic do_write(input logic bc, input logic [1:0] hart, input logic [2:0] field,
                            input logic [31:0] data, input logic exp_err,
                            input logic [NH-1:0] exp_pend);
        wr_if.wr_req_i   = 1'b1;
        wr_if.wr_bcast_i = bc;
        wr_if.wr_hart_i  = hart;
        wr_if.wr_field_i = field;
        wr_if.wr_data_i  = data;
        chk("gnt_before", 64'(wr_if.wr_gnt_o), 64'd0);
        step();
        chk("gnt", 64'(wr_if.wr_gnt_o), 64'd1);
        chk("err", 64'(wr_if.wr_err_o), 64'(exp_err));
        chk("pend_after_wr", 64'(pending_o), 64'(exp_pend));
        wr_if.wr_req_i = 1'b0;
        step();
        chk("gnt_one_cycle", 64'(wr_if.wr_gnt_o), 64'd0);
    endtask

    task automatic check_reset_state();
        for (int h = 0; h < NH; h++)
            for (int f = 0; f < NF; f++)
                chk($sformatf("rst_cfg_h%0d_f%0d", h, f), 64'(cfg_f(h, f)), 64'(32'h1000_0000 + f));
        chk("rst_pending", 64'(pending_o), 64'd0);
        chk("rst_locked", 64'(locked_o), 64'd0);
        chk("rst_done", 64'(apply_done_o), 64'd0);
        chk("rst_gnt", 64'(wr_if.wr_gnt_o), 64'd0);
        chk("rst_err", 64'(wr_if.wr_err_o), 64'd0);
    endtask

    initial begin
        rst_ni = 1'b0;
        lock_i = '0;
        apply_req_i = '0;
        hart_idle_i = '1;
        wr_if.wr_req_i = 1'b0;
        wr_if.wr_bcast_i = 1'b0;
        wr_if.wr_hart_i = '0;
        wr_if.wr_field_i = '0;
        wr_if.wr_data_i = '0;
        step();
        step();
        rst_ni = 1'b1;
        check_reset_state();

        // Single write then commit on hart 1
        do_write(1'b0, 2'd1, 3'd3, 32'hDEAD_BEEF, 1'b0, 3'b010);
        chk("h1f3_not_yet_active", 64'(cfg_f(1, 3)), 64'h1000_0003);
        apply_req_i = 3'b010;
        step();
        apply_req_i = '0;
        chk("done_not_at_1", 64'(apply_done_o), 64'd0);
        step();
        chk("done_h1", 64'(apply_done_o), 64'b010);
        step();
        chk("done_h1_drop", 64'(apply_done_o), 64'd0);
        chk("h1f3_active", 64'(cfg_f(1, 3)), 64'hDEAD_BEEF);
        chk("pend_h1_clear", 64'(pending_o), 64'd0);

        // Hart 0 waits on idle; extra requests are absorbed
        hart_idle_i = 3'b110;
        apply_req_i = 3'b001;
        step();
        for (int i = 0; i < 5; i++) begin
            apply_req_i = (i % 2 == 0) ? 3'b001 : 3'b000;
            step();
            chk($sformatf("wait_no_done_%0d", i), 64'(apply_done_o), 64'd0);
        end
        apply_req_i = '0;
        hart_idle_i = 3'b111;
        step();
        chk("done_h0_after_idle", 64'(apply_done_o), 64'b001);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("done_h0_once_%0d", i), 64'(apply_done_o), 64'd0);
        end

        // Locking and broadcast
        lock_i = 3'b001;
        step();
        lock_i = '0;
        chk("locked_h0", 64'(locked_o), 64'b001);
        do_write(1'b0, 2'd0, 3'd2, 32'h0000_1234, 1'b1, 3'b000);
        do_write(1'b1, 2'd0, 3'd2, 32'h0000_0005, 1'b0, 3'b110);
        do_write(1'b0, 2'd0, 3'd5, 32'h0000_0077, 1'b0, 3'b111);
        // lock pulse coincident with a write is checked against pre-lock state
        lock_i = 3'b010;
        wr_if.wr_req_i = 1'b1;
        wr_if.wr_bcast_i = 1'b0;
        wr_if.wr_hart_i = 2'd1;
        wr_if.wr_field_i = 3'd4;
        wr_if.wr_data_i = 32'h0000_0044;
        step();
        lock_i = '0;
        wr_if.wr_req_i = 1'b0;
        chk("lock_same_cycle_gnt", 64'(wr_if.wr_gnt_o), 64'd1);
        chk("lock_same_cycle_err", 64'(wr_if.wr_err_o), 64'd0);
        step();
        chk("locked_h01", 64'(locked_o), 64'b011);
        do_write(1'b0, 2'd1, 3'd4, 32'h0000_0099, 1'b1, 3'b111);
        apply_req_i = 3'b111;
        step();
        apply_req_i = '0;
        step();
        chk("done_all", 64'(apply_done_o), 64'b111);
        step();
        chk("h0f2_locked_keep", 64'(cfg_f(0, 2)), 64'h1000_0002);
        chk("h0f5_unmasked", 64'(cfg_f(0, 5)), 64'h0000_0077);
        chk("h1f2_bcast", 64'(cfg_f(1, 2)), 64'h0000_0005);
        chk("h2f2_bcast", 64'(cfg_f(2, 2)), 64'h0000_0005);
        chk("h1f4_prelock", 64'(cfg_f(1, 4)), 64'h0000_0044);
        chk("pend_all_clear", 64'(pending_o), 64'd0);

        // Out-of-range indices
        do_write(1'b0, 2'd2, 3'd6, 32'h0000_0111, 1'b1, 3'b000);
        do_write(1'b1, 2'd0, 3'd7, 32'h0000_0222, 1'b1, 3'b000);
        do_write(1'b0, 2'd3, 3'd1, 32'h0000_0333, 1'b1, 3'b000);

        // Write landing in hart 2's commit cycle
        apply_req_i = 3'b100;
        step();
        apply_req_i = '0;
        step();
        chk("done_h2_commit", 64'(apply_done_o), 64'b100);
        wr_if.wr_req_i = 1'b1;
        wr_if.wr_bcast_i = 1'b0;
        wr_if.wr_hart_i = 2'd2;
        wr_if.wr_field_i = 3'd0;
        wr_if.wr_data_i = 32'h0000_000A;
        step();
        wr_if.wr_req_i = 1'b0;
        chk("race_gnt", 64'(wr_if.wr_gnt_o), 64'd1);
        chk("race_err", 64'(wr_if.wr_err_o), 64'd0);
        chk("race_active_old", 64'(cfg_f(2, 0)), 64'h1000_0000);
        chk("race_pend_kept", 64'(pending_o), 64'b100);
        step();
        apply_req_i = 3'b100;
        step();
        apply_req_i = '0;
        step();
        step();
        chk("race_second_apply", 64'(cfg_f(2, 0)), 64'h0000_000A);
        chk("race_pend_clear", 64'(pending_o), 64'd0);

        // Reset in the middle of WAIT
        do_write(1'b0, 2'd2, 3'd1, 32'h0000_0055, 1'b0, 3'b100);
        hart_idle_i = 3'b011;
        apply_req_i = 3'b100;
        step();
        apply_req_i = '0;
        step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check_reset_state();
        hart_idle_i = 3'b111;
        step();
        chk("post_rst_no_done0", 64'(apply_done_o), 64'd0);
        step();
        chk("post_rst_no_done1", 64'(apply_done_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cva6_cfg_shadow_bank.md
Name: cva6_cfg_shadow_bank

Overview:
- Per-hart runtime configuration register bank with shadow/active double buffering.
- A host/debug write port updates the shadow copies. Each hart's shadow is committed to its active copy only on an apply request while that hart reports idle.
- Active values drive per-hart configuration consumers such as cache-way enables, TLB partitioning and PMP defaults.
- Generalises the static build-time configuration to multiple harts, runtime overrides, broadcast writes and per-hart lock.

Parameters:
- NrHarts, 2, number of independent configuration channels (1..16).
- NrFields, 8, configuration fields per hart (1..64).
- FieldWidth, 32, bits per field (1..64).
- RstVal, all-zero, NrFields*FieldWidth packed reset value, field f at [f*FieldWidth +: FieldWidth], shared by all harts.
- LockMask, all-ones, NrFields bits; 1 = field becomes read-only while the hart is locked.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- wr_req_i  in  1  write request; held stable until wr_gnt_o.
- wr_bcast_i  in  1  write targets every hart; wr_hart_i ignored.
- wr_hart_i  in  HW=max(1,$clog2(NrHarts))  target hart.
- wr_field_i  in  FW=max(1,$clog2(NrFields))  target field.
- wr_data_i  in  FieldWidth  write data.
- wr_gnt_o  out  1  one-cycle grant, ends the write.
- wr_err_o  out  1  valid with wr_gnt_o; write was rejected.
- lock_i  in  NrHarts  per-hart set-lock pulse; sticky until reset.
- apply_req_i  in  NrHarts  per-hart commit request pulse.
- hart_idle_i  in  NrHarts  hart is quiescent; commit is safe.
- apply_done_o  out  NrHarts  one-cycle pulse when commit completes.
- pending_o  out  NrHarts  shadow differs from active (dirty).
- locked_o  out  NrHarts  lock state.
- cfg_o  out  NrHarts*NrFields*FieldWidth  active values; hart h, field f at [(h*NrFields+f)*FieldWidth +: FieldWidth].

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - All shadow and active fields load RstVal.
  - All FSMs go to IDLE.
  - wr_gnt_o=0, wr_err_o=0, apply_done_o=0, pending_o=0, locked_o=0.
  - A write or commit in flight is dropped.
- Write port:
  - Write FSM states are W_IDLE and W_RESP.
  - In W_IDLE with wr_req_i=1, the write is checked and performed at that edge, and the FSM moves to W_RESP.
  - In W_RESP, wr_gnt_o=1 and wr_err_o reflects the check. The FSM returns to W_IDLE, and wr_req_i must drop or present a new write.
  - Grant latency is exactly 1 cycle after the request is sampled; there is at most one write every 2 cycles.
- Write error conditions:
  - wr_field_i >= NrFields.
  - Non-broadcast with wr_hart_i >= NrHarts.
  - Non-broadcast to a locked hart with LockMask[field]=1.
  - An erroring write modifies nothing.
- Broadcast writes:
  - Applied to every hart whose lock does not block the field; blocked harts are skipped silently.
  - wr_err_o=0 unless the field index is out of range.
- A successful write to hart h sets that hart's dirty flag. pending_o[h] is the dirty flag, registered.
- Per-hart commit FSM:
  - IDLE: apply_req_i[h] goes to WAIT.
  - WAIT: when hart_idle_i[h]=1, go to COMMIT. Further apply_req pulses in WAIT are absorbed.
  - COMMIT: one cycle; active <= shadow (all fields), dirty cleared, apply_done_o[h]=1 in this cycle, then IDLE.
- apply_req_i with a clean shadow still runs the full sequence; apply_done_o still pulses.
- A write to hart h in the same cycle as COMMIT for h:
  - Active receives the pre-write shadow.
  - The shadow takes the new data.
  - Dirty stays set (the write wins over the clear).
- Locking:
  - lock_i[h] sets locked_o[h] the next cycle.
  - A write in the same cycle as lock_i is checked against the pre-lock state.
- Harts are fully independent: any combination of harts may be in WAIT/COMMIT simultaneously.
- cfg_o is driven from active registers only; no combinational path from wr_data_i.

Test Plan:
- Reset, then read cfg_o -> every hart/field equals RstVal; pending_o=0, locked_o=0.
- Write hart 1 field 3 = 0xDEADBEEF -> wr_gnt_o pulses exactly 1 cycle after request, wr_err_o=0, pending_o[1]=1, cfg_o unchanged. Apply hart 1 with hart_idle_i[1]=1 -> apply_done_o[1] pulses 2 cycles after apply_req, cfg_o hart1 field3 = 0xDEADBEEF, pending_o[1]=0.
- Apply hart 0 with hart_idle_i[0]=0 for 5 cycles, then 1 -> state stays WAIT, apply_done_o[0] fires only after idle rises, and exactly once despite 3 extra apply_req pulses.
- lock_i[0], LockMask[2]=1, write hart 0 field 2 -> wr_err_o=1, shadow unchanged. Broadcast field 2 = 0x5 -> no error, hart 1 pending, hart 0 not.
- Write field index NrFields (8) or hart 2 with NrHarts=2 -> wr_err_o=1, no state change.
- Write hart 0 field 0 = 0xA landing in hart 0's COMMIT cycle -> active field 0 keeps its old value, pending_o[0] stays 1. A second apply yields 0xA. Asserting rst_ni=0 mid-WAIT -> all outputs return to reset values.
